// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and FSM encoding for the bank read-side drain
// Purpose: word width, word count, counter width and state encoding used by
//          mem_reader and mod_counter.
// Ports:   none (package).
package mem_pkg;

    localparam int WIDTH_W = 5;
    localparam int DEPTH_W = 6;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/Reg.sv
// rtl/Reg.sv - parallel-load register with synchronous clear
// Purpose: one word of storage; clear has priority over load.
// Ports:   clk    - clock, rising edge
//          clr    - synchronous clear, active high
//          en     - load d on this edge
//          d      - data in
//          q      - stored word
module Reg #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_reader_counter.sv
// rtl/mem_reader_counter.sv - word index counter that saturates at DEPTH-1
// Purpose: 3-bit synchronous counter; holds at the terminal count so it can
//          never step past the last word.
// Ports:   clk    - clock, rising edge
//          clr    - synchronous clear, active high, priority over en
//          en     - advance by one when not already at terminal count
//          cnt    - current count
//          tc     - count equals DEPTH-1
module mod_counter
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] cnt,
    output logic             tc
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST_IDX);

endmodule

// File: rtl/mem_reader.sv
// rtl/mem_reader.sv - snapshot six bank words on start and stream them out
// Purpose: on an accepted start, capture q0..q5 in one cycle, then present
//          them index 0 first over a valid/ready handshake, then pulse done.
// Ports:   clk      - clock, rising edge
//          clr_n    - synchronous reset, active low
//          start    - snapshot-and-drain request, honoured only in IDLE
//          q0..q5   - bank outputs, sampled on an accepted start
//          ready    - consumer accepts data_out this cycle
//          data_out - current word (0 when not valid)
//          valid    - data_out is meaningful
//          index    - position of the word on data_out
//          last     - valid and index is the final word
//          busy     - FSM is not idle
//          done     - one-cycle pulse after the final transfer
module mem_reader
    import mem_pkg::*;
#(
    parameter int WIDTH = WIDTH_W,
    parameter int DEPTH = DEPTH_W
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] q0,
    input  logic [WIDTH-1:0] q1,
    input  logic [WIDTH-1:0] q2,
    input  logic [WIDTH-1:0] q3,
    input  logic [WIDTH-1:0] q4,
    input  logic [WIDTH-1:0] q5,
    input  logic             ready,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic [IDX_W-1:0] index,
    output logic             last,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic             start_acc;
    logic             xfer;
    logic [IDX_W-1:0] cnt;
    logic             tc;
    logic [WIDTH-1:0] bank  [DEPTH];
    logic [WIDTH-1:0] snap  [DEPTH];
    logic [WIDTH-1:0] word;

    assign bank[0] = q0;
    assign bank[1] = q1;
    assign bank[2] = q2;
    assign bank[3] = q3;
    assign bank[4] = q4;
    assign bank[5] = q5;

    // Reset is applied through the clear inputs, so it beats a same-cycle start.
    assign start_acc = (state_q == S_IDLE) && start;
    assign xfer      = (state_q == S_SEND) && ready;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_q <= S_SEND;
                S_SEND:  if (ready && tc) state_q <= S_DONE;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_snap
        Reg #(.WIDTH(WIDTH)) u_snap (
            .clk (clk),
            .clr (~clr_n),
            .en  (start_acc),
            .d   (bank[g]),
            .q   (snap[g])
        );
    end

    mod_counter #(.DEPTH(DEPTH)) u_cnt (
        .clk (clk),
        .clr (~clr_n || start_acc),
        .en  (xfer),
        .cnt (cnt),
        .tc  (tc)
    );

    always_comb begin
        word = '0;
        case (cnt)
            3'd0:    word = snap[0];
            3'd1:    word = snap[1];
            3'd2:    word = snap[2];
            3'd3:    word = snap[3];
            3'd4:    word = snap[4];
            3'd5:    word = snap[5];
            default: word = '0;
        endcase
    end

    // Every output decodes registered state/counter/snapshot only.
    assign valid    = (state_q == S_SEND);
    assign data_out = valid ? word : '0;
    assign index    = cnt;
    assign last     = valid && tc;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_reader.sv
// tb/tb_mem_reader.sv - scoreboard bench for mem_reader
module tb_mem_reader;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       start;
    logic [4:0] q [6];
    logic       ready;
    logic [4:0] data_out;
    logic       valid;
    logic [2:0] index;
    logic       last;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    mem_reader dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .q0       (q[0]),
        .q1       (q[1]),
        .q2       (q[2]),
        .q3       (q[3]),
        .q4       (q[4]),
        .q5       (q[5]),
        .ready    (ready),
        .data_out (data_out),
        .valid    (valid),
        .index    (index),
        .last     (last),
        .busy     (busy),
        .done     (done)
    );

    typedef struct packed {
        logic [4:0] d;
        logic [2:0] i;
        logic       l;
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    logic [4:0] vec [6];
    int         checks    = 0;
    int         failures  = 0;
    int         done_seen = 0;
    int         xfers     = 0;
    logic       stall_q   = 1'b0;
    logic [4:0] stall_d;
    logic [2:0] stall_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks stall stability.
    always @(negedge clk) begin
        if (clr_n) begin
            if (stall_q) begin
                chk("hold_valid", 32'(valid), 1);
                chk("hold_data", 32'(data_out), 32'(stall_d));
                chk("hold_index", 32'(index), 32'(stall_i));
            end
            if (done) begin
                done_seen++;
                chk("done_without_valid", 32'(valid), 0);
            end
            if (valid && ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0d required=none", data_out);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("word_data", 32'(data_out), 32'(mon_e.d));
                    chk("word_index", 32'(index), 32'(mon_e.i));
                    chk("word_last", 32'(last), 32'(mon_e.l));
                end
            end
            stall_q = valid && !ready;
            stall_d = data_out;
            stall_i = index;
        end else begin
            stall_q = 1'b0;
        end
    end

    // Issue start from IDLE at posedge+1; expected words go to the scoreboard.
    task automatic start_run();
        for (int i = 0; i < 6; i++) begin
            q[i] = vec[i];
            exp_q.push_back({vec[i], 3'(i), (i == 5)});
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_latency_valid", 32'(valid), 1);
        chk("start_latency_index", 32'(index), 0);
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
    task automatic drain(input int mode, input bit zero_q, input bit poke, input bit abort3);
        int  done_before = done_seen;
        int  xfer_before = xfers;
        bit  fin   = 1'b0;
        bit  poked = 1'b0;
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            start = 1'b0;
            if (zero_q && cyc == 0)
                for (int i = 0; i < 6; i++) q[i] = 5'd0;
            if (poke && valid && index == 3'd2 && !poked) begin
                start = 1'b1;
                poked = 1'b1;
            end
            if (poke && done) start = 1'b1;
            if (abort3 && valid && index == 3'd3) begin
                clr_n = 1'b0;
                @(posedge clk); #1;
                clr_n = 1'b1;
                chk("abort_valid", 32'(valid), 0);
                chk("abort_data", 32'(data_out), 0);
                chk("abort_busy", 32'(busy), 0);
                chk("abort_done", 32'(done), 0);
                chk("abort_last", 32'(last), 0);
                exp_q.delete();
                repeat (3) @(posedge clk);
                #1;
                chk("abort_no_done_pulse", 32'(done_seen - done_before), 0);
                chk("abort_still_idle", 32'(busy), 0);
                fin = 1'b1;
            end else if (done) begin
                @(posedge clk); #1;
                start = 1'b0;
                chk("after_done_busy", 32'(busy), 0);
                chk("done_one_cycle", 32'(done), 0);
                chk("done_count", 32'(done_seen - done_before), 1);
                chk("transfer_count", 32'(xfers - xfer_before), 6);
                chk("scoreboard_empty", 32'(exp_q.size()), 0);
                fin = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=no_done required=done_within_200_cycles");
        end
        ready = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        clr_n = 1'b0;
        start = 1'b1;
        ready = 1'b0;
        for (int i = 0; i < 6; i++) q[i] = 5'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_data", 32'(data_out), 0);
        chk("reset_index", 32'(index), 0);
        chk("reset_last", 32'(last), 0);
        clr_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("reset_start_not_queued", 32'(busy), 0);

        vec = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd31};
        start_run(); drain(0, 1'b0, 1'b0, 1'b0);
        start_run(); drain(1, 1'b0, 1'b0, 1'b0);
        start_run(); drain(0, 1'b1, 1'b0, 1'b0);
        start_run(); drain(0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("late_start_ignored", 32'(busy), 0);
        start_run(); drain(0, 1'b0, 1'b0, 1'b1);
        start_run(); drain(1, 1'b0, 1'b0, 1'b0);

        vec = '{5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0};
        start_run(); drain(0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + (checks == 0 ? 1 : 0));
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
